// File: rtl/ntm_values_vector_adder_responder.sv
// Responder end of the values-vector adder: accepts operand pairs under a
// valid/ready handshake and returns element-wise unsigned sums through an output FIFO.
module ntm_values_vector_adder_responder #(
  parameter int DATA_SIZE  = 8,
  parameter int SIZE_I     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_SIZE-1:0]    ip1,
  input  logic [DATA_SIZE-1:0]    ip2,
  input  logic                    ip_valid,
  output logic                    ip_ready,
  output logic [DATA_SIZE:0]      out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(SIZE_I):0] out_index,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  localparam int SW = DATA_SIZE + 1;
  localparam int IW = $clog2(SIZE_I) + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 1 + IW + SW;
  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE_I - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [EW-1:0] mem_r [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] rd_ptr_p1_s;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic [IW-1:0] elem_cnt_r;
  logic [SW-1:0] sum_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_r;
  logic [EW-1:0] head_nxt_s;
  logic          push_s;
  logic          pop_s;
  logic          ip_ready_r;
  logic          out_valid_r;
  logic          busy_r;
  logic          done_r;
  logic          ip_ready_nxt_s;
  logic          out_valid_nxt_s;
  logic          busy_nxt_s;
  logic          done_nxt_s;

  assign push_s      = ip_valid & ip_ready_r;
  assign pop_s       = out_valid_r & out_ready;
  assign rd_ptr_p1_s = rd_ptr_r + PW'(1);

  // Sum is one bit wider than the operands so the carry is never lost.
  always_comb begin
    sum_s   = {1'b0, ip1} + {1'b0, ip2};
    entry_s = {(elem_cnt_r == LAST_IDX), elem_cnt_r, sum_s};
  end

  // Occupancy after this cycle's push/pop; push+pop together leaves it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Next registered FIFO head: a new entry lands directly when the FIFO is (or becomes) empty.
  always_comb begin
    head_nxt_s = head_r;
    if (push_s && ((count_r == {CW{1'b0}}) || ((count_r == CW'(1)) && pop_s))) begin
      head_nxt_s = entry_s;
    end else if (pop_s && (count_r > CW'(1))) begin
      head_nxt_s = mem_r[rd_ptr_p1_s];
    end else if (pop_s) begin
      head_nxt_s = {EW{1'b0}};
    end else begin
      head_nxt_s = head_r;
    end
  end

  // FSM next-state logic; start only matters in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_RUN;
        else       state_nxt_s = S_IDLE;
      end
      S_RUN: begin
        if (push_s && (elem_cnt_r == LAST_IDX)) state_nxt_s = S_DRAIN;
        else                                    state_nxt_s = S_RUN;
      end
      S_DRAIN: begin
        if (count_r == {CW{1'b0}}) state_nxt_s = S_DONE;
        else                       state_nxt_s = S_DRAIN;
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM output logic, evaluated on next-state values so the outputs can be registered.
  always_comb begin
    ip_ready_nxt_s  = (state_nxt_s == S_RUN) && (count_nxt_s < DEPTH_C);
    out_valid_nxt_s = (count_nxt_s != {CW{1'b0}});
    busy_nxt_s      = (state_nxt_s != S_IDLE);
    done_nxt_s      = (state_nxt_s == S_DONE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_r <= S_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Element counter: cleared when a vector starts, bumped on every accepted pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      elem_cnt_r <= {IW{1'b0}};
    end else if ((state_r == S_IDLE) && start) begin
      elem_cnt_r <= {IW{1'b0}};
    end else if (push_s) begin
      elem_cnt_r <= elem_cnt_r + IW'(1);
    end
  end

  // FIFO storage; contents need no reset because pointers and count gate every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= entry_s;
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      head_r   <= {EW{1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_p1_s;
      count_r <= count_nxt_s;
      head_r  <= head_nxt_s;
    end
  end

  // Registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ip_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      ip_ready_r  <= ip_ready_nxt_s;
      out_valid_r <= out_valid_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
    end
  end

  assign ip_ready  = ip_ready_r;
  assign out_valid = out_valid_r;
  assign out       = head_r[SW-1:0];
  assign out_index = head_r[SW +: IW];
  assign out_last  = head_r[EW-1];
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_ntm_values_vector_adder_responder.sv
// Directed self-checking bench for the values-vector adder responder.
module tb_ntm_values_vector_adder_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] ip1;
  logic [7:0] ip2;
  logic       ip_valid;
  logic       ip_ready;
  logic [8:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_index;
  logic       out_last;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  int va[4];
  int vb[4];
  int ve[4];

  ntm_values_vector_adder_responder #(
    .DATA_SIZE(8), .SIZE_I(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ip1(ip1), .ip2(ip2),
    .ip_valid(ip_valid), .ip_ready(ip_ready), .out(out), .out_valid(out_valid),
    .out_ready(out_ready), .out_index(out_index), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full vector with out_ready=1; poke pulses start during RUN and DRAIN.
  task automatic do_vector(input string tag, input bit poke);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_run"}, busy, 1);
    chk({tag, "_ready_run"}, ip_ready, 1);
    ip_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ip1 = va[i][7:0];
      ip2 = vb[i][7:0];
      start = poke && (i == 1);
      tick();
      chk({tag, "_valid"}, out_valid, 1);
      chk({tag, "_out"}, out, ve[i]);
      chk({tag, "_index"}, out_index, i);
      chk({tag, "_last"}, out_last, (i == 3) ? 1 : 0);
      chk({tag, "_ready"}, ip_ready, (i == 3) ? 0 : 1);
      chk({tag, "_nodone"}, done, 0);
    end
    ip_valid = 1'b0;
    start = poke;
    tick();
    start = 1'b0;
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_done_early"}, done, 0);
    chk({tag, "_busy_drain"}, busy, 1);
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_done"}, busy, 1);
    tick();
    chk({tag, "_done_once"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_ready_idle"}, ip_ready, 0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; ip1 = 8'd0; ip2 = 8'd0; ip_valid = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk("rst_ip_ready", ip_ready, 0);
    chk("rst_out", out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;
    tick();

    va = '{1, 10, 100, 0};  vb = '{2, 20, 27, 0};  ve = '{3, 30, 127, 0};
    do_vector("basic", 1'b0);

    va = '{255, 255, 128, 0};  vb = '{255, 1, 128, 255};  ve = '{510, 256, 256, 255};
    do_vector("carry", 1'b0);

    // Backpressure: four pairs pile up, the first result must hold steady.
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ip_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ip1 = 8'(i + 1);
      ip2 = 8'(i + 1);
      tick();
      chk("bp_hold_out", out, 2);
      chk("bp_hold_idx", out_index, 0);
      chk("bp_ready", ip_ready, (i < 3) ? 1 : 0);
    end
    ip_valid = 1'b0;
    tick();
    chk("bp_stall_out", out, 2);
    chk("bp_stall_valid", out_valid, 1);
    chk("bp_stall_ready", ip_ready, 0);
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("bp_drain_out", out, (i + 1) * 2);
      chk("bp_drain_idx", out_index, i);
    end
    tick();
    chk("bp_empty", out_valid, 0);
    tick();
    chk("bp_done", done, 1);
    tick();
    chk("bp_idle", busy, 0);

    // FIFO holding two entries, then push and pop together.
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ip_valid = 1'b1;
    ip1 = 8'd5; ip2 = 8'd5;
    tick();
    chk("sim_first", out, 10);
    ip1 = 8'd6; ip2 = 8'd6;
    tick();
    chk("sim_hold", out, 10);
    chk("sim_hold_idx", out_index, 0);
    out_ready = 1'b1;
    ip1 = 8'd7; ip2 = 8'd7;
    tick();
    chk("sim_pp1_out", out, 12);
    chk("sim_pp1_idx", out_index, 1);
    chk("sim_pp1_ready", ip_ready, 1);
    ip1 = 8'd8; ip2 = 8'd8;
    tick();
    chk("sim_pp2_out", out, 14);
    chk("sim_pp2_idx", out_index, 2);
    chk("sim_pp2_ready", ip_ready, 0);
    ip_valid = 1'b0;
    tick();
    chk("sim_pp3_out", out, 16);
    chk("sim_pp3_last", out_last, 1);
    tick();
    chk("sim_empty", out_valid, 0);
    tick();
    chk("sim_done", done, 1);
    tick();
    chk("sim_idle", busy, 0);

    // Reset in the middle of a vector with one result still pending.
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ip_valid = 1'b1;
    ip1 = 8'd1; ip2 = 8'd1;
    tick();
    ip1 = 8'd2; ip2 = 8'd2;
    tick();
    chk("mid_pending_valid", out_valid, 1);
    chk("mid_pending_out", out, 4);
    out_ready = 1'b0;
    ip_valid = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", ip_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    tick();
    chk("mid_rst_done2", done, 0);
    chk("mid_rst_busy2", busy, 0);
    va = '{9, 1, 2, 3};  vb = '{9, 0, 0, 0};  ve = '{18, 1, 2, 3};
    do_vector("fresh", 1'b0);

    // start pulses while busy must not restart or clear the vector.
    va = '{20, 30, 40, 50};  vb = '{1, 2, 3, 4};  ve = '{21, 32, 43, 54};
    do_vector("busy_start", 1'b1);
    tick();
    chk("busy_start_noextra_busy", busy, 0);
    chk("busy_start_noextra_valid", out_valid, 0);
    chk("busy_start_noextra_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
